operand_fetch: RTL and testbench

Operand fetch responder for the tensor-core datapath: consumes the per-cycle read requests produced by the address generator (`en`, byte-granular `rdaddr_A`/`rdaddr_B`, `cmen`), issues the reads to the A and B operand SRAMs and extracts the addressed element per data type. It queues the results in a small FIFO and hands them to the systolic array head over a valid/ready interface. It applies back-pressure to the address generator with a credit-style `stall_out`.

---
 rtl/operand_fetch_if.sv | 42 ++++
 rtl/operand_fetch.sv | 161 ++++++++++++++++
 tb/tb_operand_fetch.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Operand fetch bus: address-generator requests, A/B SRAM read ports and the
// valid/ready operand stream toward the systolic array head.
interface operand_fetch_if #(
    parameter int unsigned SRAM_AW = 10
);
    logic               en_in;
    logic               cmen_in;
    logic [1:0]         datatype;
    logic [31:0]        rdaddr_A;
    logic [31:0]        rdaddr_B;
    logic               stall_out;

    logic               sram_A_ren;
    logic               sram_B_ren;
    logic [SRAM_AW-1:0] sram_A_addr;
    logic [SRAM_AW-1:0] sram_B_addr;
    logic [31:0]        sram_A_rdata;
    logic [31:0]        sram_B_rdata;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_A;
    logic [31:0]        out_B;
    logic               out_cmen;
    logic               err;

    // Environment side: address generator, SRAM models and consumer.
    modport master (
        output en_in, cmen_in, datatype, rdaddr_A, rdaddr_B,
        output sram_A_rdata, sram_B_rdata, out_ready,
        input  stall_out, sram_A_ren, sram_B_ren, sram_A_addr, sram_B_addr,
        input  out_valid, out_A, out_B, out_cmen, err
    );

    // Operand fetch block side.
    modport slave (
        input  en_in, cmen_in, datatype, rdaddr_A, rdaddr_B,
        input  sram_A_rdata, sram_B_rdata, out_ready,
        output stall_out, sram_A_ren, sram_B_ren, sram_A_addr, sram_B_addr,
        output out_valid, out_A, out_B, out_cmen, err
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch responder: issues A/B SRAM reads, extracts the addressed element
// per data type and queues results in a credit-protected FIFO.
module operand_fetch #(
    parameter int unsigned SRAM_AW = 10,
    parameter int unsigned DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [1:0] DT_FP16 = 2'd1;
    localparam logic [1:0] DT_INT8 = 2'd2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cmen;
    } entry_t;

    // Pick the addressed element out of a 32-bit SRAM word.
    function automatic logic [31:0] extract(input logic [1:0]  dt,
                                            input logic [1:0]  off,
                                            input logic [31:0] w);
        logic [7:0]  byte_v;
        logic [31:0] r;
        r      = w;
        byte_v = w[{off, 3'b000} +: 8];
        case (dt)
            DT_FP16: r = off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
            DT_INT8: r = {{24{byte_v[7]}}, byte_v};
            default: r = w;
        endcase
        return r;
    endfunction

    logic          s1_valid_q;
    logic [1:0]    s1_dt_q;
    logic          s1_cmen_q;
    logic [1:0]    s1_off_a_q;
    logic [1:0]    s1_off_b_q;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q;

    logic          stall_c;
    logic          acc_c;
    logic          push_c;
    logic          pop_c;
    logic          out_valid_c;
    entry_t        push_entry_c;
    entry_t        head_c;

    // Credit check uses only registered occupancy, never the same-cycle pop.
    assign stall_c = (SW'(count_q) + SW'(s1_valid_q)) >= SW'(DEPTH);
    assign acc_c   = bus.en_in & ~stall_c;

    assign bus.stall_out   = stall_c;
    assign bus.sram_A_ren  = acc_c;
    assign bus.sram_B_ren  = acc_c;
    assign bus.sram_A_addr = bus.rdaddr_A[SRAM_AW+1:2];
    assign bus.sram_B_addr = bus.rdaddr_B[SRAM_AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rdaddr_A[31:SRAM_AW+2], bus.rdaddr_B[31:SRAM_AW+2]};

    // S1: request sideband aligned with the returning SRAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_dt_q    <= 2'd0;
            s1_cmen_q  <= 1'b0;
            s1_off_a_q <= 2'd0;
            s1_off_b_q <= 2'd0;
        end else begin
            s1_valid_q <= acc_c;
            if (acc_c) begin
                s1_dt_q    <= bus.datatype;
                s1_cmen_q  <= bus.cmen_in;
                s1_off_a_q <= bus.rdaddr_A[1:0];
                s1_off_b_q <= bus.rdaddr_B[1:0];
            end
        end
    end

    always_comb begin
        push_entry_c      = '0;
        push_entry_c.a    = extract(s1_dt_q, s1_off_a_q, bus.sram_A_rdata);
        push_entry_c.b    = extract(s1_dt_q, s1_off_b_q, bus.sram_B_rdata);
        push_entry_c.cmen = s1_cmen_q;
    end

    assign push_c      = s1_valid_q;
    assign out_valid_c = (count_q != '0);
    assign pop_c       = out_valid_c & bus.out_ready;

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wr_ptr_q] <= push_entry_c;
        end
    end

    // Sticky protocol error; the offending request was already dropped by acc_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.en_in && stall_c) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        head_c = '0;
        if (out_valid_c) begin
            head_c = mem_q[rd_ptr_q];
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_A     = head_c.a;
    assign bus.out_B     = head_c.b;
    assign bus.out_cmen  = head_c.cmen;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Randomized bench for operand_fetch against a queue-based request/response model.
module tb_operand_fetch;
    localparam int unsigned SRAM_AW = 10;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned WORDS   = 1 << SRAM_AW;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cmen;
        int          rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.SRAM_AW(SRAM_AW)) bus ();

    operand_fetch #(.SRAM_AW(SRAM_AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem_a [WORDS];
    logic [31:0] mem_b [WORDS];

    // SRAM models: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        bus.sram_A_rdata <= bus.sram_A_ren ? mem_a[bus.sram_A_addr] : $urandom;
        bus.sram_B_rdata <= bus.sram_B_ren ? mem_b[bus.sram_B_addr] : $urandom;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_pop    = 0;
    bit   err_m    = 1'b0;
    exp_t q[$];

    bit          seen_ren;
    bit          seen_stall;
    bit          seen_valid;
    bit          seen_pop;
    logic [31:0] seen_out_a;
    logic [31:0] seen_addr_a;
    logic [31:0] seen_addr_b;

    function automatic logic [31:0] model_elem(input logic [1:0] dt, input logic [1:0] o,
                                               input logic [31:0] w);
        int b;
        if (dt == 2'd1) return (w >> (o >= 2 ? 16 : 0)) & 32'h0000FFFF;
        if (dt == 2'd2) begin
            b = int'((w >> (8 * int'(o))) & 32'hFF);
            if (b >= 128) b = b - 256;
            return 32'(b);
        end
        return w;
    endfunction

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr / 4) % WORDS);
    endfunction

    // One clock of traffic: drive inputs, compare every observable with the model, advance.
    task automatic step(input bit en, input bit cm, input logic [1:0] dt,
                        input logic [31:0] aa, input logic [31:0] ab, input bit rdy);
        bit   s_exp, acc, v_exp, viol;
        exp_t e, h;
        bus.en_in = en; bus.cmen_in = cm; bus.datatype = dt;
        bus.rdaddr_A = aa; bus.rdaddr_B = ab; bus.out_ready = rdy;
        #1;
        s_exp = (n_acc - n_pop) >= DEPTH;
        acc   = en && !s_exp;
        viol  = en && s_exp;
        v_exp = (q.size() > 0) && (q[0].rdy <= cyc);
        n_checks++;
        if (bus.stall_out !== s_exp) begin
            n_fail++; $display("FAIL stall_out cyc=%0d got=%b exp=%b", cyc, bus.stall_out, s_exp);
        end
        n_checks++;
        if (bus.sram_A_ren !== acc || bus.sram_B_ren !== acc) begin
            n_fail++; $display("FAIL ren cyc=%0d got=%b/%b exp=%b", cyc, bus.sram_A_ren, bus.sram_B_ren, acc);
        end
        if (acc) begin
            n_checks++;
            if (int'(bus.sram_A_addr) != word_idx(aa) || int'(bus.sram_B_addr) != word_idx(ab)) begin
                n_fail++; $display("FAIL sram_addr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                                   bus.sram_A_addr, bus.sram_B_addr, word_idx(aa), word_idx(ab));
            end
        end
        n_checks++;
        if (bus.out_valid !== v_exp) begin
            n_fail++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, v_exp);
        end
        h.a = '0; h.b = '0; h.cmen = 1'b0; h.rdy = 0;
        if (v_exp) h = q[0];
        n_checks++;
        if (bus.out_A !== h.a || bus.out_B !== h.b || bus.out_cmen !== h.cmen) begin
            n_fail++; $display("FAIL out_data cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc,
                               bus.out_A, bus.out_B, bus.out_cmen, h.a, h.b, h.cmen);
        end
        n_checks++;
        if (bus.err !== err_m) begin
            n_fail++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, bus.err, err_m);
        end
        seen_ren = bus.sram_A_ren; seen_stall = bus.stall_out; seen_valid = bus.out_valid;
        seen_pop = bus.out_valid && rdy; seen_out_a = bus.out_A;
        seen_addr_a = 32'(bus.sram_A_addr); seen_addr_b = 32'(bus.sram_B_addr);
        if (acc) begin
            e.a    = model_elem(dt, aa[1:0], mem_a[word_idx(aa)]);
            e.b    = model_elem(dt, ab[1:0], mem_b[word_idx(ab)]);
            e.cmen = cm;
            e.rdy  = cyc + 2;
            q.push_back(e);
            n_acc++;
        end
        if (v_exp && rdy) begin
            void'(q.pop_front());
            n_pop++;
        end
        @(posedge clk); #1;
        cyc++;
        if (viol) err_m = 1'b1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        bus.en_in = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        q.delete(); n_acc = 0; n_pop = 0; err_m = 1'b0;
    endtask

    // Single request on an empty FIFO; returns first output and its latency.
    task automatic run_one(input logic [1:0] dt, input logic [31:0] aa, input logic [31:0] ab,
                           output logic [31:0] got, output int lat);
        got = 'x; lat = -1;
        step(1'b1, 1'b0, dt, aa, ab, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            if (seen_valid && lat < 0) begin got = seen_out_a; lat = i; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        idle(2, 1'b1);
        n_checks++;
        if (seen_valid !== 1'b0 || seen_stall !== 1'b0 || seen_ren !== 1'b0) begin
            n_fail++; $display("FAIL reset_state got valid=%b stall=%b ren=%b exp 0", seen_valid, seen_stall, seen_ren);
        end
    endtask

    task automatic test_fp32_stream();
        int outs = 0, stalls = 0, first = -1;
        mem_a[1] = 32'h3F800000;
        step(1'b1, 1'b1, 2'd0, 32'd4, 32'd8, 1'b1);
        n_checks++;
        if (seen_addr_a != 32'd1 || seen_addr_b != 32'd2) begin
            n_fail++; $display("FAIL fp32_addr got=%0d/%0d exp=1/2", seen_addr_a, seen_addr_b);
        end
        for (int i = 1; i < 8; i++) begin
            step(1'b1, i[0], 2'd0, 32'd4, 32'd8, 1'b1);
            if (seen_stall) stalls++;
            if (seen_valid) begin outs++; if (first < 0) first = i; end
        end
        for (int i = 8; i < 12; i++) begin
            step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            if (seen_valid) outs++;
        end
        n_checks++;
        if (outs != 8 || stalls != 0 || first != 2) begin
            n_fail++; $display("FAIL fp32_stream got outs=%0d stalls=%0d first=%0d exp 8/0/2", outs, stalls, first);
        end
    endtask

    task automatic test_extract();
        logic [1:0]  dts  [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        logic [31:0] adrs [6] = '{32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 32'd4};
        logic [31:0] want [6] = '{32'h0000CAFE, 32'h00008081, 32'hFFFFFF81,
                                  32'hFFFFFF80, 32'hFFFFFFCA, 32'h76543210};
        logic [31:0] got;
        int          lat;
        mem_a[0] = 32'hCAFE8081;
        mem_a[1] = 32'h76543210;
        for (int i = 0; i < 6; i++) begin
            run_one(dts[i], adrs[i], 32'($urandom), got, lat);
            n_checks++;
            if (got !== want[i] || lat != 2) begin
                n_fail++; $display("FAIL extract[%0d] got=%h lat=%0d exp=%h lat=2", i, got, lat, want[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        int          accepts = 0, first_pop = -1, stall_on = -1;
        logic [31:0] exp_a [DEPTH];
        int          popped = 0;
        bit          st;
        for (int i = 0; i < 10; i++) begin
            st = (n_acc - n_pop) >= DEPTH;
            step(!st, 1'b1, 2'd0, 32'(i * 4 + 64), 32'(i * 4 + 128), 1'b0);
            if (seen_ren) begin
                if (accepts < DEPTH) exp_a[accepts] = mem_a[i + 16];
                accepts++;
            end
            if (seen_stall && stall_on < 0) stall_on = i;
        end
        n_checks++;
        if (accepts != DEPTH || stall_on != DEPTH || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_fill got acc=%0d stall_at=%0d err=%b exp %0d/%0d/0",
                               accepts, stall_on, bus.err, DEPTH, DEPTH);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            if (first_pop >= 0 && i == first_pop + 1) begin
                n_checks++;
                if (seen_stall !== 1'b0) begin
                    n_fail++; $display("FAIL stall_release got=%b exp=0", seen_stall);
                end
            end
            if (seen_pop) begin
                if (first_pop < 0) first_pop = i;
                n_checks++;
                if (popped >= DEPTH || seen_out_a !== exp_a[popped]) begin
                    n_fail++; $display("FAIL pop_order[%0d] got=%h", popped, seen_out_a);
                end
                popped++;
            end
        end
        n_checks++;
        if (popped != DEPTH) begin
            n_fail++; $display("FAIL pop_count got=%0d exp=%0d", popped, DEPTH);
        end
    endtask

    task automatic test_violation();
        int pops = 0;
        bit st;
        for (int i = 0; i < 6; i++) begin
            st = (n_acc - n_pop) >= DEPTH;
            step(!st, 1'b0, 2'd2, 32'($urandom), 32'($urandom), 1'b0);
        end
        step(1'b1, 1'b1, 2'd0, 32'h40, 32'h80, 1'b0);
        n_checks++;
        if (seen_ren !== 1'b0 || seen_stall !== 1'b1) begin
            n_fail++; $display("FAIL violation_ren got ren=%b stall=%b exp 0/1", seen_ren, seen_stall);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            if (seen_pop) pops++;
        end
        n_checks++;
        if (bus.err !== 1'b1 || pops != DEPTH) begin
            n_fail++; $display("FAIL violation_sticky got err=%b pops=%0d exp 1/%0d", bus.err, pops, DEPTH);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] got;
        int          lat;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd0, 32'($urandom), 32'($urandom), 1'b0);
        do_reset();
        step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        n_checks++;
        if (seen_valid !== 1'b0 || seen_stall !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got valid=%b stall=%b err=%b exp 0", seen_valid, seen_stall, bus.err);
        end
        mem_a[5] = 32'h12345678;
        run_one(2'd0, 32'd20, 32'd0, got, lat);
        n_checks++;
        if (got !== 32'h12345678 || lat != 2) begin
            n_fail++; $display("FAIL post_reset got=%h lat=%0d exp=12345678 lat=2", got, lat);
        end
    endtask

    task automatic test_random();
        bit st;
        for (int i = 0; i < 400; i++) begin
            st = (n_acc - n_pop) >= DEPTH;
            step(($urandom_range(0, 3) != 0) && !st, 1'($urandom), 2'($urandom),
                 $urandom, $urandom, $urandom_range(0, 9) < 6);
        end
        idle(DEPTH + 4, 1'b1);
        n_checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL random_drain got left=%0d valid=%b exp 0/0", q.size(), bus.out_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        bus.en_in = 1'b0; bus.cmen_in = 1'b0; bus.datatype = 2'd0;
        bus.rdaddr_A = '0; bus.rdaddr_B = '0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fp32_stream();
        test_extract();
        test_back_pressure();
        test_violation();
        do_reset();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
